// File: rtl/datapath_seq_ctrl_pkg.sv
// Shared definitions for the datapath sequencer: ISA encodings, IR field
// positions, controller states and the decoded instruction-class bundle.
package datapath_seq_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam int OPC_HI = 15, OPC_LO = 13;
  localparam int OP_HI  = 12, OP_LO  = 11;
  localparam int RN_HI  = 10, RN_LO  = 8;
  localparam int RD_HI  = 7,  RD_LO  = 5;
  localparam int SH_HI  = 4,  SH_LO  = 3;
  localparam int RM_HI  = 2,  RM_LO  = 0;
  localparam int IMM8_W = 8;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_C, S_WR_IMM, S_ERR
  } state_t;

  typedef struct packed {
    logic mov_imm;
    logic mov_reg;
    logic alu_rr;   // ADD, CMP, AND: both operands read from registers
    logic cmp;
    logic mvn;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/datapath_seq_ctrl_decode.sv
// Combinational IR field extraction, sximm8 generation and instruction
// class flags.
module instr_field_decode
  import datapath_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [DATA_W-1:0] ir,
  output logic [REG_AW-1:0] rn,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rm,
  output logic [1:0]        sh,
  output logic [1:0]        op,
  output logic [DATA_W-1:0] sximm8,
  output instr_class_t      cls
);

  logic [2:0] opcode;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign op     = ir[OP_HI:OP_LO];
  assign rn     = ir[RN_HI:RN_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign rm     = ir[RM_HI:RM_LO];
  assign sh     = ir[SH_HI:SH_LO];
  assign sximm8 = {{(DATA_W-IMM8_W){ir[IMM8_W-1]}}, ir[IMM8_W-1:0]};

  always_comb begin
    cls         = '0;
    cls.mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    cls.mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    cls.mvn     = (opcode == OPC_ALU) && (op == OP_MVN);
    cls.alu_rr  = (opcode == OPC_ALU) && (op != OP_MVN);
    cls.cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
    cls.illegal = !(cls.mov_imm || cls.mov_reg || cls.mvn || cls.alu_rr);
  end

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Multicycle Moore controller sequencing register read, ALU, status and
// write-back for the 8-register datapath; one instruction per start.
module datapath_seq_ctrl
  import datapath_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [DATA_W-1:0] instr,
  output logic              w,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic              vsel,
  output logic [1:0]        shift,
  output logic [1:0]        aluop,
  output logic [DATA_W-1:0] sximm8,
  output logic              illegal
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ir;
  logic [REG_AW-1:0] rn, rd, rm;
  logic [1:0]        sh, op;
  instr_class_t      cls;

  instr_field_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .op     (op),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  // IR only loads on an accepted start, so it is stable while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && s) ir <= instr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (s) state_nxt = S_DECODE;
      S_DECODE: begin
        if (cls.illegal)                  state_nxt = S_ERR;
        else if (cls.mov_imm)             state_nxt = S_WR_IMM;
        else if (cls.mov_reg || cls.mvn)  state_nxt = S_GET_B;
        else if (cls.alu_rr)              state_nxt = S_GET_A;
        else                              state_nxt = S_ERR;
      end
      S_GET_A:  state_nxt = S_GET_B;
      S_GET_B:  state_nxt = S_ALU;
      S_ALU:    state_nxt = cls.cmp ? S_WAIT : S_WR_C;
      S_WR_C:   state_nxt = S_WAIT;
      S_WR_IMM: state_nxt = S_WAIT;
      S_ERR:    state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w        = (state == S_WAIT);
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    shift    = 2'b00;
    aluop    = 2'b00;
    illegal  = 1'b0;
    case (state)
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        // MOV reg and MVN pass B through with A forced to zero.
        asel  = cls.mov_reg || cls.mvn;
        aluop = cls.mov_reg ? 2'b00 : op;
        loads = cls.cmp;
        loadc = !cls.cmp;
      end
      S_WR_C: begin
        write    = 1'b1;
        writenum = rd;
      end
      S_WR_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = rn;
      end
      S_ERR:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Directed-vector bench for datapath_seq_ctrl with hand-computed expectations.
module tb_datapath_seq_ctrl;

  logic        clk, reset, s;
  logic [15:0] instr;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, vsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, aluop;
  logic [15:0] sximm8;
  logic [4:0]  stb;

  int checks = 0;
  int failures = 0;

  assign stb = {write, loada, loadb, loadc, loads};

  datapath_seq_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .aluop(aluop),
    .sximm8(sximm8), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after s was sampled (cycle 1).
  task automatic start(input logic [15:0] i);
    s = 1'b1;
    instr = i;
    tick();
    s = 1'b0;
  endtask

  initial begin
    int nload_s, nload_c, nwrite;
    reset = 1'b1; s = 1'b0; instr = 16'h0000;
    #12;
    chk("rst_w", w, 1);
    chk("rst_stb", stb, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_sximm8", sximm8, 16'h0000);
    tick();
    reset = 1'b0;
    tick();

    // MOV R1, #-2
    start(16'hD1FE);
    chk("movi_c1_w", w, 0);
    chk("movi_c1_stb", stb, 0);
    tick();
    chk("movi_c2_stb", stb, 5'b10000);
    chk("movi_c2_vsel", vsel, 1);
    chk("movi_c2_wnum", writenum, 1);
    chk("movi_c2_sx", sximm8, 16'hFFFE);
    tick();
    chk("movi_c3_w", w, 1);
    chk("movi_c3_stb", stb, 0);

    // ADD R2,R1,R0,LSL#1 with s toggled while busy
    start(16'hA148);
    instr = 16'h0000;
    s = 1'b1;
    tick();
    chk("add_c2_stb", stb, 5'b01000);
    chk("add_c2_rnum", readnum, 1);
    s = 1'b0;
    tick();
    chk("add_c3_stb", stb, 5'b00100);
    chk("add_c3_rnum", readnum, 0);
    s = 1'b1;
    tick();
    chk("add_c4_stb", stb, 5'b00010);
    chk("add_c4_shift", shift, 2'b01);
    chk("add_c4_aluop", aluop, 2'b00);
    chk("add_c4_asel", asel, 0);
    s = 1'b0;
    tick();
    chk("add_c5_stb", stb, 5'b10000);
    chk("add_c5_wnum", writenum, 2);
    chk("add_c5_vsel", vsel, 0);
    chk("add_c5_rnum", readnum, 0);
    chk("add_ir_kept", sximm8, 16'h0048);
    tick();
    chk("add_c6_w", w, 1);

    // CMP R0,R1: count strobes across cycles 1..4, w at 5
    start(16'hA801);
    nload_s = 0; nload_c = 0; nwrite = 0;
    for (int c = 1; c <= 4; c++) begin
      chk("cmp_busy_w", w, 0);
      nload_s += int'(loads);
      nload_c += int'(loadc);
      nwrite  += int'(write);
      if (c < 4) tick();
    end
    chk("cmp_aluop", aluop, 2'b01);
    tick();
    chk("cmp_c5_w", w, 1);
    chk("cmp_loads_n", nload_s, 1);
    chk("cmp_loadc_n", nload_c, 0);
    chk("cmp_write_n", nwrite, 0);

    // MVN R3,R0
    start(16'hB860);
    tick();
    chk("mvn_c2_stb", stb, 5'b00100);
    chk("mvn_c2_rnum", readnum, 0);
    tick();
    chk("mvn_c3_stb", stb, 5'b00010);
    chk("mvn_c3_asel", asel, 1);
    chk("mvn_c3_aluop", aluop, 2'b11);
    tick();
    chk("mvn_c4_stb", stb, 5'b10000);
    chk("mvn_c4_wnum", writenum, 3);
    tick();
    chk("mvn_c5_w", w, 1);

    // Illegal opcode
    start(16'h0000);
    chk("ill_c1", illegal, 0);
    tick();
    chk("ill_c2", illegal, 1);
    chk("ill_c2_stb", stb, 0);
    tick();
    chk("ill_c3", illegal, 0);
    chk("ill_c3_w", w, 1);

    // Back-to-back: s held high through a MOV imm, next start in WAIT
    s = 1'b1; instr = 16'hD1FE;
    tick(); tick();
    chk("b2b_c2_write", write, 1);
    instr = 16'hA801;
    tick();
    chk("b2b_c3_w", w, 1);
    tick();
    s = 1'b0;
    chk("b2b_c4_w", w, 0);
    chk("b2b_ir", sximm8, 16'h0001);
    tick(); tick(); tick(); tick();
    chk("b2b_cmp_done", w, 1);

    // Reset mid-ADD while in ALU
    start(16'hA148);
    tick(); tick(); tick();
    chk("rmid_alu_loadc", loadc, 1);
    #2 reset = 1'b1;
    #1;
    chk("rmid_stb", stb, 0);
    chk("rmid_w", w, 1);
    tick();
    chk("rmid_nowrite", write, 0);
    chk("rmid_ir_clr", sximm8, 16'h0000);
    reset = 1'b0;
    tick();
    chk("rmid_idle_w", w, 1);
    chk("rmid_idle_stb", stb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
